game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 10: score that ends the game (range 1..15).
REQ-002 Parameter SHOTS_PER_TURN, default 3: shots granted per turn (range 1..7).
REQ-003 Parameter TIMEOUT_TICKS, default 255: idle ticks before forfeit (used only with GAME_CTRL_TURN_TIMER_EN).
REQ-004 clk  in  1  single clock, the divided pixel clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 start  in  1  level from the start switch.
REQ-007 tick  in  1  one-clk game-tick strobe.
REQ-008 shot_fired  in  1  one-clk pulse: fire button accepted by the display stage.
REQ-009 shot_done  in  1  one-clk pulse: bullet left the screen.
REQ-010 hit  in  1  one-clk pulse: bullet struck the target.
REQ-011 state  out  2  QI=00, QGAME_1=01, QGAME_2=10, QDONE=11.
REQ-012 p1_score, p2_score  out  4 each  player scores, binary.
REQ-013 active_player  out  1  0=player 1, 1=player 2.
REQ-014 shots_left  out  3  remaining shots in the current turn.
REQ-015 fire_en  out  1  display stage may launch a bullet.
REQ-016 turn_reset  out  1  one-clk pulse: display stage re-centres ship and target.
REQ-017 winner  out  2  00=none, 01=player 1, 10=player 2.

Function
REQ-018 All outputs registered; each responds to a sampled input one clk later.
REQ-019 QI: start 0->1 edge (previous-cycle register) -> QGAME_1; clear scores, shots_left=SHOTS_PER_TURN, winner=00, pulse turn_reset.
REQ-020 fire_en = (state is QGAME_1 or QGAME_2) and shots_left>0 and no shot in flight.
REQ-021 shot_fired with fire_en=1: shots_left-1, in_flight set; with fire_en=0: ignored.
REQ-022 hit with in_flight: active player's score +1, in_flight cleared; hit without in_flight: ignored.
REQ-023 shot_done with in_flight: in_flight cleared, no score change.
REQ-024 hit and shot_done in the same cycle: one hit only.
REQ-025 Score saturates at WIN_SCORE; on reaching it: -> QDONE next cycle, winner set, fire_en=0.
REQ-026 shots_left=0 and in_flight=0 and no win: switch turn (QGAME_1<->QGAME_2), toggle active_player, reload shots_left, pulse turn_reset.
REQ-027 start=0 in any state other than QI: -> QI next cycle; scores and winner held until the next game start.
REQ-028 QDONE holds all outputs until start=0.
REQ-029 Inputs arriving in QI or QDONE are ignored.

Reset
REQ-030 reset=0 at a clk edge: state=QI, scores=0, active_player=0, shots_left=0, in_flight=0, fire_en=0, turn_reset=0, winner=00, start-edge register=1 (a switch already high does not start a game).
REQ-031 Reset mid-game discards all game state; no turn_reset pulse is issued.

Configuration
REQ-032 Macro GAME_CTRL_TURN_TIMER_EN defined: idle counter increments on tick while fire_en=1; it clears on an accepted shot or a turn switch; at TIMEOUT_TICKS it forces shots_left=0, so the turn switches per REQ-026.
REQ-033 Macro undefined: no timer logic; a turn ends only by exhausting shots.

Structure
REQ-034 Shared package astro_pkg holds the state encodings, winner encodings and the score/shot widths; the display stage uses the same package.
REQ-035 Sub-module turn_timer (counter plus compare) is instantiated only under GAME_CTRL_TURN_TIMER_EN.

Verification
REQ-036 Release reset with start=1 -> state stays 00; start 0 then 1 -> state=01, shots_left=3, one turn_reset pulse.
REQ-037 In QGAME_1: fire, hit, fire, done, fire, done -> p1_score=1, then state=10, active_player=1, shots_left=3.
REQ-038 hit and shot_done in the same cycle -> score +1 once; a second shot_fired while in_flight -> shots_left unchanged.
REQ-039 WIN_SCORE=2, player 2 hits twice -> state=11, winner=10, fire_en=0; then start=0 -> state=00.
REQ-040 With GAME_CTRL_TURN_TIMER_EN and TIMEOUT_TICKS=4, no shots for 4 ticks -> shots_left=0 and the turn switches; without the macro -> no switch after 1000 ticks.
REQ-041 reset=0 mid-flight in QGAME_2 -> next cycle all outputs at their REQ-030 values.

Source files
------------

// File: rtl/astro_pkg.sv
// astro_pkg: shared encodings and widths for the game controller and display stage.
//   Exports: SCORE_W, SHOT_W, game_state_t, winner_t, in_game().
package astro_pkg;
    localparam int SCORE_W = 4;
    localparam int SHOT_W = 3;
    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } game_state_t;
    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_t;
    function automatic logic in_game(input game_state_t s);
        return s == QGAME_1 || s == QGAME_2;
    endfunction
endpackage

// File: rtl/game_ctrl_turn_timer.sv
// turn_timer: idle-tick counter that flags a forfeited turn.
//   clk, reset (sync, active-low), tick (game tick strobe), run (count enable),
//   clear (restart count), expired (count reached TIMEOUT_TICKS).
module turn_timer #(
    parameter int TIMEOUT_TICKS = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);
    logic [CW-1:0] count;
    assign expired = count == CW'(TIMEOUT_TICKS);
    always_ff @(posedge clk) begin
        if (!reset || clear)
            count <= '0;
        else if (tick && run && !expired)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: two-player turn/score controller for the shooting game.
//   Inputs : clk, reset (sync, active-low), start (switch level), tick,
//            shot_fired, shot_done, hit (one-clk pulses).
//   Outputs: state, p1_score, p2_score, active_player, shots_left, fire_en,
//            turn_reset, winner -- all registered.
//   Option : GAME_CTRL_TURN_TIMER_EN adds an idle-tick forfeit via turn_timer.
module game_ctrl
    import astro_pkg::*;
#(
    parameter int WIN_SCORE      = 10,
    parameter int SHOTS_PER_TURN = 3,
    parameter int TIMEOUT_TICKS  = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tick,
    input  logic               shot_fired,
    input  logic               shot_done,
    input  logic               hit,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               active_player,
    output logic [SHOT_W-1:0]  shots_left,
    output logic               fire_en,
    output logic               turn_reset,
    output logic [1:0]         winner
);
    game_state_t        st;
    winner_t            win_r;
    logic               start_q, in_flight;
    logic               accepted, scored, cleared, won, switch_turn, expired, in_flight_next;
    logic [SCORE_W-1:0] cur_score, inc_score;
    logic [SHOT_W-1:0]  shots_next;

    assign state  = st;
    assign winner = win_r;

    // A hit takes precedence over shot_done; both only count while a bullet is in flight.
    always_comb begin
        accepted       = shot_fired && fire_en;
        scored         = hit && in_flight;
        cleared        = (hit || shot_done) && in_flight;
        cur_score      = active_player ? p2_score : p1_score;
        inc_score      = (cur_score >= SCORE_W'(WIN_SCORE)) ? cur_score : cur_score + 1'b1;
        won            = scored && inc_score == SCORE_W'(WIN_SCORE);
        switch_turn    = in_game(st) && shots_left == '0 && !in_flight;
        shots_next     = expired ? '0 : accepted ? shots_left - 1'b1 : shots_left;
        in_flight_next = accepted || (in_flight && !cleared);
    end

`ifdef GAME_CTRL_TURN_TIMER_EN
    turn_timer #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .run     (fire_en),
        .clear   (accepted || switch_turn || !in_game(st)),
        .expired (expired)
    );
`else
    localparam int unused_timeout = TIMEOUT_TICKS;
    logic unused_tick;
    assign unused_tick = tick;
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            st            <= QI;
            p1_score      <= '0;
            p2_score      <= '0;
            active_player <= 1'b0;
            shots_left    <= '0;
            in_flight     <= 1'b0;
            fire_en       <= 1'b0;
            turn_reset    <= 1'b0;
            win_r         <= WIN_NONE;
            start_q       <= 1'b1;
        end else begin
            start_q    <= start;
            turn_reset <= 1'b0;
            if (st == QI) begin
                if (start && !start_q) begin
                    st            <= QGAME_1;
                    p1_score      <= '0;
                    p2_score      <= '0;
                    active_player <= 1'b0;
                    shots_left    <= SHOT_W'(SHOTS_PER_TURN);
                    in_flight     <= 1'b0;
                    fire_en       <= 1'b1;
                    turn_reset    <= 1'b1;
                    win_r         <= WIN_NONE;
                end
            end else if (!start) begin
                // Scores and winner stay visible until the next game starts.
                st         <= QI;
                shots_left <= '0;
                in_flight  <= 1'b0;
                fire_en    <= 1'b0;
            end else if (switch_turn) begin
                st            <= (st == QGAME_1) ? QGAME_2 : QGAME_1;
                active_player <= !active_player;
                shots_left    <= SHOT_W'(SHOTS_PER_TURN);
                in_flight     <= 1'b0;
                fire_en       <= 1'b1;
                turn_reset    <= 1'b1;
            end else if (won) begin
                st        <= QDONE;
                win_r     <= active_player ? WIN_P2 : WIN_P1;
                in_flight <= 1'b0;
                fire_en   <= 1'b0;
                if (active_player)
                    p2_score <= inc_score;
                else
                    p1_score <= inc_score;
            end else if (st != QDONE) begin
                if (scored && !active_player)
                    p1_score <= inc_score;
                if (scored && active_player)
                    p2_score <= inc_score;
                shots_left <= shots_next;
                in_flight  <= in_flight_next;
                fire_en    <= shots_next != '0 && !in_flight_next;
            end
        end
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed self-checking bench for game_ctrl (WIN_SCORE=2, 3 shots, timeout 4).
module tb_game_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b1;
    logic       tick = 1'b0;
    logic       shot_fired = 1'b0;
    logic       shot_done = 1'b0;
    logic       hit = 1'b0;
    logic [1:0] state;
    logic [3:0] p1_score, p2_score;
    logic       active_player;
    logic [2:0] shots_left;
    logic       fire_en, turn_reset;
    logic [1:0] winner;
    int         checks = 0;
    int         errors = 0;

    game_ctrl #(.WIN_SCORE(2), .SHOTS_PER_TURN(3), .TIMEOUT_TICKS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
        .shot_fired(shot_fired), .shot_done(shot_done), .hit(hit),
        .state(state), .p1_score(p1_score), .p2_score(p2_score),
        .active_player(active_player), .shots_left(shots_left),
        .fire_en(fire_en), .turn_reset(turn_reset), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        shot_fired = 1'b0;
        shot_done  = 1'b0;
        hit        = 1'b0;
        tick       = 1'b0;
    endtask

    task automatic fire();
        shot_fired = 1'b1;
        step();
    endtask

    task automatic miss();
        shot_done = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b1;
        step();
        step();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state got=%b exp=00", state); end
        checks++; if ({p1_score, p2_score} !== 8'h00) begin errors++; $display("FAIL rst_scores got=%h exp=00", {p1_score, p2_score}); end
        checks++; if ({active_player, shots_left, fire_en, turn_reset, winner} !== 8'h00) begin errors++; $display("FAIL rst_misc got=%h exp=00", {active_player, shots_left, fire_en, turn_reset, winner}); end
        reset = 1'b1;
        repeat (3) step();
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL held_start_state got=%b exp=00", state); end
    endtask

    task automatic test_start();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL start_state got=%b exp=01", state); end
        checks++; if (shots_left !== 3'd3) begin errors++; $display("FAIL start_shots got=%0d exp=3", shots_left); end
        checks++; if (turn_reset !== 1'b1) begin errors++; $display("FAIL start_turn_reset got=%b exp=1", turn_reset); end
        checks++; if (fire_en !== 1'b1) begin errors++; $display("FAIL start_fire_en got=%b exp=1", fire_en); end
        step();
        checks++; if (turn_reset !== 1'b0) begin errors++; $display("FAIL turn_reset_pulse got=%b exp=0", turn_reset); end
    endtask

    task automatic test_turn();
        fire();
        checks++; if ({shots_left, fire_en} !== {3'd2, 1'b0}) begin errors++; $display("FAIL fire1 got=%0d/%b exp=2/0", shots_left, fire_en); end
        hit = 1'b1;
        step();
        checks++; if (p1_score !== 4'd1) begin errors++; $display("FAIL hit1 got=%0d exp=1", p1_score); end
        checks++; if (fire_en !== 1'b1) begin errors++; $display("FAIL hit1_fire_en got=%b exp=1", fire_en); end
        fire();
        miss();
        checks++; if ({p1_score, shots_left} !== {4'd1, 3'd1}) begin errors++; $display("FAIL miss2 got=%0d/%0d exp=1/1", p1_score, shots_left); end
        fire();
        miss();
        checks++; if ({state, shots_left, fire_en} !== {2'b01, 3'd0, 1'b0}) begin errors++; $display("FAIL last_shot got=%b/%0d/%b exp=01/0/0", state, shots_left, fire_en); end
        step();
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL switch_state got=%b exp=10", state); end
        checks++; if ({active_player, shots_left, turn_reset} !== {1'b1, 3'd3, 1'b1}) begin errors++; $display("FAIL switch_misc got=%b/%0d/%b exp=1/3/1", active_player, shots_left, turn_reset); end
    endtask

    task automatic test_same_cycle();
        fire();
        fire();
        checks++; if (shots_left !== 3'd2) begin errors++; $display("FAIL refire_in_flight got=%0d exp=2", shots_left); end
        hit = 1'b1;
        shot_done = 1'b1;
        step();
        checks++; if ({state, p2_score} !== {2'b10, 4'd1}) begin errors++; $display("FAIL hit_and_done got=%b/%0d exp=10/1", state, p2_score); end
        fire();
        miss();
        fire();
        miss();
        step();
        checks++; if ({state, active_player, shots_left} !== {2'b01, 1'b0, 3'd3}) begin errors++; $display("FAIL switch_back got=%b/%b/%0d exp=01/0/3", state, active_player, shots_left); end
    endtask

    task automatic test_win();
        start = 1'b0;
        step();
        checks++; if ({state, p1_score, p2_score} !== {2'b00, 4'd1, 4'd1}) begin errors++; $display("FAIL abort_hold got=%b/%0d/%0d exp=00/1/1", state, p1_score, p2_score); end
        start = 1'b1;
        step();
        checks++; if ({state, p1_score, p2_score} !== {2'b01, 4'd0, 4'd0}) begin errors++; $display("FAIL restart got=%b/%0d/%0d exp=01/0/0", state, p1_score, p2_score); end
        repeat (3) begin
            fire();
            miss();
        end
        step();
        fire();
        hit = 1'b1;
        step();
        checks++; if ({state, p2_score} !== {2'b10, 4'd1}) begin errors++; $display("FAIL p2_first got=%b/%0d exp=10/1", state, p2_score); end
        fire();
        hit = 1'b1;
        step();
        checks++; if ({state, winner, fire_en, p2_score} !== {2'b11, 2'b10, 1'b0, 4'd2}) begin errors++; $display("FAIL win got=%b/%b/%b/%0d exp=11/10/0/2", state, winner, fire_en, p2_score); end
        shot_fired = 1'b1;
        hit = 1'b1;
        step();
        checks++; if ({state, p2_score, shots_left} !== {2'b11, 4'd2, 3'd1}) begin errors++; $display("FAIL done_ignores got=%b/%0d/%0d exp=11/2/1", state, p2_score, shots_left); end
        start = 1'b0;
        step();
        checks++; if ({state, winner, p2_score} !== {2'b00, 2'b10, 4'd2}) begin errors++; $display("FAIL done_exit got=%b/%b/%0d exp=00/10/2", state, winner, p2_score); end
    endtask

    task automatic test_timer();
        start = 1'b1;
        step();
        checks++; if ({state, winner, shots_left} !== {2'b01, 2'b00, 3'd3}) begin errors++; $display("FAIL timer_start got=%b/%b/%0d exp=01/00/3", state, winner, shots_left); end
`ifdef GAME_CTRL_TURN_TIMER_EN
        repeat (4) begin
            tick = 1'b1;
            step();
        end
        checks++; if (shots_left !== 3'd3) begin errors++; $display("FAIL timer_early got=%0d exp=3", shots_left); end
        step();
        checks++; if ({state, shots_left, fire_en} !== {2'b01, 3'd0, 1'b0}) begin errors++; $display("FAIL timer_expire got=%b/%0d/%b exp=01/0/0", state, shots_left, fire_en); end
        step();
        checks++; if ({state, active_player, shots_left} !== {2'b10, 1'b1, 3'd3}) begin errors++; $display("FAIL timer_switch got=%b/%b/%0d exp=10/1/3", state, active_player, shots_left); end
`else
        repeat (1000) begin
            tick = 1'b1;
            step();
        end
        checks++; if ({state, active_player, shots_left} !== {2'b01, 1'b0, 3'd3}) begin errors++; $display("FAIL no_timer got=%b/%b/%0d exp=01/0/3", state, active_player, shots_left); end
`endif
    endtask

    task automatic test_reset_mid();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
        repeat (3) begin
            fire();
            miss();
        end
        step();
        fire();
        checks++; if ({state, shots_left, fire_en} !== {2'b10, 3'd2, 1'b0}) begin errors++; $display("FAIL mid_flight got=%b/%0d/%b exp=10/2/0", state, shots_left, fire_en); end
        reset = 1'b0;
        step();
        checks++; if ({state, p1_score, p2_score, active_player, shots_left, fire_en, turn_reset, winner} !== 17'h0) begin errors++; $display("FAIL mid_reset got=%h exp=0", {state, p1_score, p2_score, active_player, shots_left, fire_en, turn_reset, winner}); end
        reset = 1'b1;
        step();
        step();
        checks++; if ({state, turn_reset} !== 3'b000) begin errors++; $display("FAIL post_reset got=%b/%b exp=00/0", state, turn_reset); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_turn();
        test_same_cycle();
        test_win();
        test_timer();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
